oven_cook_ctrl: RTL and testbench

- Top-level sequencing FSM for the FPGA oven.
- Takes the power switch and four active-low push-buttons, and owns the target temperature and the cook-time countdown.
- Runs a simple first-order thermal model of the cavity and drives the heater enable and the done alarm.
- Its state, temperature and time outputs feed the BCD/seven-segment display path; it sits between the board inputs and that display path.

---
 rtl/oven_pkg.sv | 48 ++++
 rtl/btn_sync_edge.sv | 39 +++
 rtl/oven_cook_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_oven_cook_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oven_pkg.sv
// Shared constants and types for the oven controller.
//   - TEMP_W / TIME_W : widths of the temperature and cook-time datapaths
//   - temperature limits, model rates and cook-time limits
//   - state_t         : FSM state encoding (also driven onto the display path)
//   - sat_add/sat_sub : saturating 12-bit step helpers used by the setters
//                       and the thermal model
package oven_pkg;

    localparam int TEMP_W = 11;
    localparam int TIME_W = 12;

    localparam int TEMP_MIN     = 150;
    localparam int TEMP_MAX     = 550;
    localparam int TEMP_DEFAULT = 357;
    localparam int TEMP_STEP    = 5;
    localparam int AMBIENT      = 70;
    localparam int HEAT_RATE    = 10;
    localparam int COOL_RATE    = 3;
    localparam int HYST         = 5;
    localparam int TIME_MAX     = 3599;
    localparam int TIME_STEP    = 30;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET_TEMP = 3'd1,
        ST_SET_TIME = 3'd2,
        ST_PREHEAT  = 3'd3,
        ST_COOK     = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // All callers pass values well below 2^12, so v + inc cannot wrap.
    function automatic logic [11:0] sat_add(input logic [11:0] v,
                                            input logic [11:0] inc,
                                            input logic [11:0] hi);
        logic [11:0] sum;
        sum = v + inc;
        return (sum > hi) ? hi : sum;
    endfunction

    // Compare against lo + dec first so v - dec never goes below zero.
    function automatic logic [11:0] sat_sub(input logic [11:0] v,
                                            input logic [11:0] dec,
                                            input logic [11:0] lo);
        return (v < lo + dec) ? lo : v - dec;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser with edge-to-pulse conversion for one board input.
//   clk, rst : system clock, asynchronous active-high reset
//   pin      : raw asynchronous board input
//   level    : synchronised level, active-true (inverted when ACTIVE_LOW)
//   press    : one-cycle pulse on the synchronised inactive->active edge
// The flops reset to the inactive level so that a pin already at its idle
// level after reset never produces a spurious press.
module btn_sync_edge #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic press
);

    logic meta;
    logic sync;
    logic sync_d;

    // NOTE: clocked state always uses non-blocking assignments so that every
    // flop samples the pre-edge value of its neighbour (a true shift chain).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= ACTIVE_LOW;
            sync   <= ACTIVE_LOW;
            sync_d <= ACTIVE_LOW;
        end else begin
            meta   <= pin;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign level = sync ^ ACTIVE_LOW;
    assign press = level & ~(sync_d ^ ACTIVE_LOW);

endmodule

// File: rtl/oven_cook_ctrl.sv
// Top-level sequencing FSM for the FPGA oven.
//   clk, rst       : system clock, asynchronous active-high reset
//   power_sw       : oven power level (asynchronous)
//   btn_*_n        : active-low mode / up / down / start push-buttons
//   state          : FSM state code for the display path
//   target_temp    : settable target temperature
//   cur_temp       : first-order thermal model of the cavity
//   time_left      : remaining cook seconds
//   heat_on, alarm : heater enable, cook-finished alarm
//   tick           : one-cycle pulse every TICK_CYCLES clocks (1 s)
// Presses take three cycles from pin to action: two synchroniser flops, then
// the FSM register. Per-cycle event priority: power off > start > mode > up/dn.
module oven_cook_ctrl
    import oven_pkg::*;
#(
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              power_sw,
    input  logic              btn_mode_n,
    input  logic              btn_up_n,
    input  logic              btn_dn_n,
    input  logic              btn_start_n,
    output logic [2:0]        state,
    output logic [TEMP_W-1:0] target_temp,
    output logic [TEMP_W-1:0] cur_temp,
    output logic [TIME_W-1:0] time_left,
    output logic              heat_on,
    output logic              alarm,
    output logic              tick
);

    localparam int              CNT_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] tick_cnt;

    logic       pwr_on;
    logic       pwr_rise_unused;
    logic [3:0] btn_level_unused;
    logic       mode_p, up_p, dn_p, start_p;

    btn_sync_edge #(.ACTIVE_LOW(1'b0)) u_pwr (
        .clk(clk), .rst(rst), .pin(power_sw),
        .level(pwr_on), .press(pwr_rise_unused)
    );
    btn_sync_edge #(.ACTIVE_LOW(1'b1)) u_mode (
        .clk(clk), .rst(rst), .pin(btn_mode_n),
        .level(btn_level_unused[0]), .press(mode_p)
    );
    btn_sync_edge #(.ACTIVE_LOW(1'b1)) u_up (
        .clk(clk), .rst(rst), .pin(btn_up_n),
        .level(btn_level_unused[1]), .press(up_p)
    );
    btn_sync_edge #(.ACTIVE_LOW(1'b1)) u_dn (
        .clk(clk), .rst(rst), .pin(btn_dn_n),
        .level(btn_level_unused[2]), .press(dn_p)
    );
    btn_sync_edge #(.ACTIVE_LOW(1'b1)) u_start (
        .clk(clk), .rst(rst), .pin(btn_start_n),
        .level(btn_level_unused[3]), .press(start_p)
    );

    // Datapath in 12 bits so heat/step additions cannot wrap.
    logic        wrap;
    logic [11:0] cur_ext, tgt_ext;
    logic [11:0] temp_heated, temp_cooled;
    logic [11:0] tgt_inc, tgt_dec, time_inc, time_dec;
    logic        at_target, below_band;
    logic        up_only, dn_only, any_press;

    assign wrap        = (tick_cnt == CNT_LAST);
    assign cur_ext     = {1'b0, cur_temp};
    assign tgt_ext     = {1'b0, target_temp};
    assign temp_heated = sat_add(cur_ext, 12'(HEAT_RATE), 12'(TEMP_MAX));
    assign temp_cooled = sat_sub(cur_ext, 12'(COOL_RATE), 12'(AMBIENT));
    assign tgt_inc     = sat_add(tgt_ext, 12'(TEMP_STEP), 12'(TEMP_MAX));
    assign tgt_dec     = sat_sub(tgt_ext, 12'(TEMP_STEP), 12'(TEMP_MIN));
    assign time_inc    = sat_add(time_left, 12'(TIME_STEP), 12'(TIME_MAX));
    assign time_dec    = sat_sub(time_left, 12'(TIME_STEP), 12'd0);
    assign at_target   = (cur_ext >= tgt_ext);
    assign below_band  = (cur_ext < (tgt_ext - 12'(HYST)));
    // Simultaneous up and down cancel out.
    assign up_only     = up_p & ~dn_p;
    assign dn_only     = dn_p & ~up_p;
    assign any_press   = start_p | mode_p | up_p | dn_p;

    assign state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            target_temp <= TEMP_W'(TEMP_DEFAULT);
            cur_temp    <= TEMP_W'(AMBIENT);
            time_left   <= '0;
            heat_on     <= 1'b0;
            alarm       <= 1'b0;
            tick        <= 1'b0;
            tick_cnt    <= '0;
        end else begin
            // Tick counter and thermal model run regardless of FSM state; the
            // model uses the heater value in force during the elapsed second.
            tick_cnt <= wrap ? '0 : tick_cnt + CNT_W'(1);
            tick     <= wrap;
            if (wrap) begin
                cur_temp <= heat_on ? temp_heated[TEMP_W-1:0] : temp_cooled[TEMP_W-1:0];
            end

            if (!pwr_on) begin
                state_q   <= ST_IDLE;
                heat_on   <= 1'b0;
                alarm     <= 1'b0;
                time_left <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_SET_TEMP;

                    ST_SET_TEMP, ST_SET_TIME: begin
                        // A start with no cook time still consumes the cycle.
                        if (start_p) begin
                            if (time_left != '0) begin
                                state_q <= ST_PREHEAT;
                                heat_on <= 1'b1;
                            end
                        end else if (mode_p) begin
                            state_q <= (state_q == ST_SET_TEMP) ? ST_SET_TIME : ST_SET_TEMP;
                        end else if (up_only) begin
                            if (state_q == ST_SET_TEMP) target_temp <= tgt_inc[TEMP_W-1:0];
                            else                        time_left   <= time_inc;
                        end else if (dn_only) begin
                            if (state_q == ST_SET_TEMP) target_temp <= tgt_dec[TEMP_W-1:0];
                            else                        time_left   <= time_dec;
                        end
                    end

                    ST_PREHEAT: begin
                        if (start_p) begin
                            state_q <= ST_SET_TEMP;
                            heat_on <= 1'b0;
                        end else if (at_target) begin
                            state_q <= ST_COOK;
                        end
                    end

                    ST_COOK: begin
                        if (start_p) begin
                            state_q <= ST_SET_TEMP;
                            heat_on <= 1'b0;
                        end else if (wrap && time_left == 12'd1) begin
                            time_left <= '0;
                            state_q   <= ST_DONE;
                            heat_on   <= 1'b0;
                            alarm     <= 1'b1;
                        end else begin
                            if (wrap) time_left <= time_left - 12'd1;
                            // Bang-bang with a band below target; hold in between.
                            if (below_band)     heat_on <= 1'b1;
                            else if (at_target) heat_on <= 1'b0;
                        end
                    end

                    ST_DONE: begin
                        if (any_press) begin
                            alarm   <= 1'b0;
                            state_q <= ST_SET_TEMP;
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                        heat_on <= 1'b0;
                        alarm   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oven_cook_ctrl.sv
// Self-checking bench for oven_cook_ctrl: directed walk through the main
// scenarios followed by random button/power activity, all compared each cycle
// against a behavioural model built from the oven's rules.
module tb_oven_cook_ctrl;

    localparam int TICK = 4;

    // Oven rules, written independently of the design package.
    localparam int R_TMIN = 150, R_TMAX = 550, R_TDEF = 357, R_TSTEP = 5;
    localparam int R_AMB = 70, R_HEAT = 10, R_COOL = 3, R_HYST = 5;
    localparam int R_XMAX = 3599, R_XSTEP = 30;

    localparam int B_MODE = 1, B_UP = 2, B_DN = 3, B_START = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        power_sw = 1'b1;
    logic        btn_mode_n = 1'b1, btn_up_n = 1'b1, btn_dn_n = 1'b1, btn_start_n = 1'b1;
    logic [2:0]  state;
    logic [10:0] target_temp, cur_temp;
    logic [11:0] time_left;
    logic        heat_on, alarm, tick;

    oven_cook_ctrl #(.TICK_CYCLES(TICK)) dut (
        .clk(clk), .rst(rst), .power_sw(power_sw),
        .btn_mode_n(btn_mode_n), .btn_up_n(btn_up_n),
        .btn_dn_n(btn_dn_n), .btn_start_n(btn_start_n),
        .state(state), .target_temp(target_temp), .cur_temp(cur_temp),
        .time_left(time_left), .heat_on(heat_on), .alarm(alarm), .tick(tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // States: 0 idle, 1 set temp, 2 set time, 3 preheat, 4 cook, 5 done.
    int m_state, m_target, m_cur, m_time, m_cnt;
    bit m_heat, m_alarm, m_tick;
    // hist[i][k]: pin i as sampled k+1 edges ago (0 power, 1..4 buttons).
    bit hist [5][3];

    function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
    function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

    // A press acts once the 1->0 edge has crossed two synchroniser stages.
    function automatic bit fell(input int i);
        return hist[i][2] && !hist[i][1];
    endfunction

    task automatic model_reset();
        m_state = 0; m_target = R_TDEF; m_cur = R_AMB; m_time = 0; m_cnt = 0;
        m_heat = 0; m_alarm = 0; m_tick = 0;
        for (int k = 0; k < 3; k++) begin
            hist[0][k] = 1'b0;
            for (int i = 1; i < 5; i++) hist[i][k] = 1'b1;
        end
    endtask

    task automatic model_step();
        bit pins [5];
        bit pwr, p_mode, p_up, p_dn, p_start, wrap;
        int old_cur;
        pins[0] = power_sw; pins[1] = btn_mode_n; pins[2] = btn_up_n;
        pins[3] = btn_dn_n; pins[4] = btn_start_n;
        pwr = hist[0][1];
        p_mode = fell(1); p_up = fell(2); p_dn = fell(3); p_start = fell(4);
        wrap = (m_cnt == TICK - 1);
        old_cur = m_cur;
        if (wrap) m_cur = m_heat ? imin(m_cur + R_HEAT, R_TMAX) : imax(m_cur - R_COOL, R_AMB);
        m_tick = wrap;
        m_cnt  = wrap ? 0 : m_cnt + 1;
        if (!pwr) begin
            m_state = 0; m_heat = 0; m_alarm = 0; m_time = 0;
        end else begin
            case (m_state)
                0: m_state = 1;
                1, 2: begin
                    if (p_start) begin
                        if (m_time > 0) begin m_state = 3; m_heat = 1; end
                    end else if (p_mode) begin
                        m_state = 3 - m_state;
                    end else if (p_up != p_dn) begin
                        if (m_state == 1) m_target = p_up ? imin(m_target + R_TSTEP, R_TMAX)
                                                          : imax(m_target - R_TSTEP, R_TMIN);
                        else              m_time   = p_up ? imin(m_time + R_XSTEP, R_XMAX)
                                                          : imax(m_time - R_XSTEP, 0);
                    end
                end
                3: begin
                    if (p_start)                 begin m_state = 1; m_heat = 0; end
                    else if (old_cur >= m_target) m_state = 4;
                end
                4: begin
                    if (p_start) begin
                        m_state = 1; m_heat = 0;
                    end else if (wrap && m_time == 1) begin
                        m_time = 0; m_state = 5; m_heat = 0; m_alarm = 1;
                    end else begin
                        if (wrap) m_time--;
                        if (old_cur < m_target - R_HYST) m_heat = 1;
                        else if (old_cur >= m_target)    m_heat = 0;
                    end
                end
                default: begin
                    if (p_start || p_mode || p_up || p_dn) begin m_alarm = 0; m_state = 1; end
                end
            endcase
        end
        for (int i = 0; i < 5; i++) begin
            hist[i][2] = hist[i][1];
            hist[i][1] = hist[i][0];
            hist[i][0] = pins[i];
        end
    endtask

    task automatic compare_all();
        check("state",       state,       m_state);
        check("target_temp", target_temp, m_target);
        check("cur_temp",    cur_temp,    m_cur);
        check("time_left",   time_left,   m_time);
        check("heat_on",     heat_on,     m_heat);
        check("alarm",       alarm,       m_alarm);
        check("tick",        tick,        m_tick);
    endtask

    // One clock: model advances on the edge, DUT compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            B_MODE:  btn_mode_n  = v;
            B_UP:    btn_up_n    = v;
            B_DN:    btn_dn_n    = v;
            default: btn_start_n = v;
        endcase
    endtask

    task automatic press(input int idx);
        set_btn(idx, 1'b0);
        cycle();
        set_btn(idx, 1'b1);
        cycles(2);
    endtask

    task automatic run_until(input int want, input int budget, input string tag);
        int n;
        n = 0;
        while (m_state != want && n < budget) begin
            cycle();
            n++;
        end
        check(tag, state, want);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},  state,       0);
        check({tag, "_target"}, target_temp, R_TDEF);
        check({tag, "_cur"},    cur_temp,    R_AMB);
        check({tag, "_time"},   time_left,   0);
        check({tag, "_heat"},   heat_on,     0);
        check({tag, "_alarm"},  alarm,       0);
        check({tag, "_tick"},   tick,        0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int exp_temp;
        bit reached;
        model_reset();

        // Reset state, then power comes up into SET_TEMP.
        cycles(2);
        check_reset_values("reset");
        rst = 1'b0;
        cycles(4);
        check("power_up_state", state, 1);

        // Target adjust and saturation at the low end.
        for (int i = 0; i < 3; i++) press(B_UP);
        check("up3_target", target_temp, 372);
        for (int i = 0; i < 50; i++) press(B_DN);
        check("dn_sat_target", target_temp, R_TMIN);

        // Start ignored with no cook time; mode and time set.
        press(B_START);
        check("start_no_time", state, 1);
        press(B_MODE);
        press(B_UP);
        press(B_UP);
        check("set_time_state", state, 2);
        check("set_time_value", time_left, 60);

        // Preheat ramp from ambient to the 150 target.
        press(B_START);
        check("preheat_state", state, 3);
        check("preheat_heat", heat_on, 1);
        exp_temp = 80;
        reached  = 0;
        for (int i = 0; i < 200 && !reached; i++) begin
            cycle();
            if (m_tick) begin
                check("preheat_ramp", cur_temp, exp_temp);
                if (exp_temp == 150) reached = 1;
                else                 exp_temp += R_HEAT;
            end
        end
        check("preheat_reached", reached, 1);
        cycle();
        check("cook_entry", state, 4);

        // Cook countdown to DONE, then acknowledge with mode.
        run_until(5, 400, "done_reached");
        check("done_alarm", alarm, 1);
        check("done_heat", heat_on, 0);
        check("done_time", time_left, 0);
        press(B_MODE);
        check("ack_alarm", alarm, 0);
        check("ack_state", state, 1);

        // Power drop mid-cook.
        press(B_MODE);
        press(B_UP);
        press(B_START);
        run_until(4, 200, "cook_again");
        power_sw = 1'b0;
        cycles(3);
        check("pwr_off_state", state, 0);
        check("pwr_off_heat", heat_on, 0);
        check("pwr_off_time", time_left, 0);
        check("pwr_off_target", target_temp, R_TMIN);
        cycles(200);
        check("cool_floor", cur_temp, R_AMB);

        // Simultaneous up and down leave the target alone.
        power_sw = 1'b1;
        cycles(4);
        check("repower_state", state, 1);
        press(B_UP);
        check("up_once", target_temp, 155);
        btn_up_n = 1'b0;
        btn_dn_n = 1'b0;
        cycle();
        btn_up_n = 1'b1;
        btn_dn_n = 1'b1;
        cycles(2);
        check("up_dn_same", target_temp, 155);

        // Asynchronous reset mid-preheat.
        press(B_MODE);
        press(B_UP);
        press(B_START);
        check("preheat2_state", state, 3);
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        #1 check_reset_values("async_rst");
        cycles(2);
        rst = 1'b0;

        // Random activity against the model.
        for (int i = 0; i < 3000; i++) begin
            power_sw    = ($urandom_range(0, 499) != 0);
            btn_mode_n  = ($urandom_range(0, 7)   != 0);
            btn_up_n    = ($urandom_range(0, 3)   != 0);
            btn_dn_n    = ($urandom_range(0, 4)   != 0);
            btn_start_n = ($urandom_range(0, 59)  != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
